pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the in-order datapath, replacing fixed per-stage latch blocks between decode, execute, memory and writeback. It carries a control field and a data field, and adds three things to the stage boundary:
- a valid/ready handshake with an optional two-entry skid buffer for back-pressure,
- bubble insertion that zeroes the control field while keeping the data,
- a synchronous flush.

A saturating counter reports how many bubbles the stage has inserted.

---
 rtl/pipe_stage_reg_if.sv | 30 +++
 rtl/pipe_stage_reg.sv | 152 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bundle for pipe_stage_reg: upstream handshake, downstream handshake,
// stage controls and status. master = the side driving the stage, slave = the stage.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              bubble;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output in_valid, in_ctrl, in_data, bubble, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy, bubble_cnt
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, bubble, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, bubble insertion, flush and a
// saturating bubble counter. Define PIPE_SKID_EN to add the two-entry skid buffer.
module pipe_stage_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  pipe_stage_reg_if.slave bus
);
  logic              in_fire;
  logic              out_fire;
  logic              m_valid;
  logic              s_valid;
  logic [CTRL_W-1:0] in_ctrl_eff;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CTRL_W-1:0] out_ctrl_w;

  assign in_fire     = bus.in_valid & bus.in_ready;
  assign out_fire    = m_valid & bus.out_ready;
  assign in_ctrl_eff = bus.bubble ? {CTRL_W{1'b0}} : bus.in_ctrl;

`ifdef PIPE_SKID_EN
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;

  // Entry validity is decoded from the state so in_ready never sees out_ready.
  assign m_valid      = (state_q == ST_ONE) | (state_q == ST_FULL);
  assign s_valid      = (state_q == ST_FULL);
  assign bus.in_ready = ~s_valid & ~bus.flush;

  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d  = ST_ONE;
            m_ctrl_d = in_ctrl_eff;
            m_data_d = bus.in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            m_ctrl_d = in_ctrl_eff;
            m_data_d = bus.in_data;
          end else if (in_fire) begin
            state_d  = ST_FULL;
            s_ctrl_d = in_ctrl_eff;
            s_data_d = bus.in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d  = ST_ONE;
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      s_ctrl_q <= '0;
      s_data_q <= '0;
    end else begin
      state_q  <= state_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
    end
  end
`else
  logic m_valid_q, m_valid_d;

  assign m_valid      = m_valid_q;
  assign s_valid      = 1'b0;
  assign bus.in_ready = (~m_valid_q | bus.out_ready) & ~bus.flush;

  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    if (bus.flush) begin
      m_valid_d = 1'b0;
    end else if (in_fire) begin
      m_valid_d = 1'b1;
      m_ctrl_d  = in_ctrl_eff;
      m_data_d  = bus.in_data;
    end else if (out_fire) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
    end
  end
`endif

  // in_fire is already blocked by flush, so flushing never moves the counter.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (in_fire && bus.bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl_q     <= '0;
      m_data_q     <= '0;
      bubble_cnt_q <= '0;
    end else begin
      m_ctrl_q     <= m_ctrl_d;
      m_data_q     <= m_data_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_out_ctrl
    assign out_ctrl_w[gi] = m_ctrl_q[gi] & m_valid;
  end

  assign bus.out_valid  = m_valid;
  assign bus.out_ctrl   = out_ctrl_w;
  assign bus.out_data   = m_data_q;
  assign bus.occupancy  = {1'b0, m_valid} + {1'b0, s_valid};
  assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: scoreboard on the main instance plus a
// CNT_W=2 instance for counter saturation. Works with or without PIPE_SKID_EN.
`timescale 1ns/1ps
module tb_pipe_stage_reg;
  localparam int DW = 160;
  localparam int CW = 9;
  localparam int NW = 16;
`ifdef PIPE_SKID_EN
  localparam int MAXOCC = 2;
`else
  localparam int MAXOCC = 1;
`endif

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  int   bub_exp = 0;
  ent_t sb[$];
  ent_t exp_e;
  ent_t new_e;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) bus_m ();
  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(CW), .CNT_W(2))  bus_s ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) u_dut (
    .clk(clk), .reset(reset), .bus(bus_m)
  );
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(CW), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .bus(bus_s)
  );

  always #5 clk = ~clk;

  // Scoreboard: the DUT updates on the falling edge, so sample on the rising edge.
  always @(posedge clk) begin
    if (!reset) begin
      if (bus_m.out_valid && bus_m.out_ready) begin
        checks++;
        pops++;
        $display("tx out ctrl=%h data=%h", bus_m.out_ctrl, bus_m.out_data);
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got ctrl=%h data=%h, required no entry", bus_m.out_ctrl, bus_m.out_data);
        end else begin
          exp_e = sb.pop_front();
          if ({bus_m.out_ctrl, bus_m.out_data} !== exp_e) begin
            failures++;
            $display("FAIL sb_entry: got ctrl=%h data=%h, required ctrl=%h data=%h",
                     bus_m.out_ctrl, bus_m.out_data, exp_e.ctrl, exp_e.data);
          end
        end
      end
      if (bus_m.flush) begin
        sb.delete();
      end else if (bus_m.in_valid && bus_m.in_ready) begin
        new_e.ctrl = bus_m.bubble ? {CW{1'b0}} : bus_m.in_ctrl;
        new_e.data = bus_m.in_data;
        sb.push_back(new_e);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus_m.in_valid  = 1'b0;
    bus_m.in_ctrl   = '0;
    bus_m.in_data   = '0;
    bus_m.bubble    = 1'b0;
    bus_m.flush     = 1'b0;
    bus_m.out_ready = 1'b1;
    bus_s.in_valid  = 1'b0;
    bus_s.in_ctrl   = '0;
    bus_s.in_data   = '0;
    bus_s.bubble    = 1'b0;
    bus_s.flush     = 1'b0;
    bus_s.out_ready = 1'b1;
  endtask

  task automatic drain();
    idle();
    for (int k = 0; k < 8 && sb.size() != 0; k++) step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    checks++; if (bus_m.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", bus_m.out_valid); end
    reset = 1'b0;
    #1;
    checks++; if (bus_m.out_ctrl !== '0) begin failures++; $display("FAIL reset_out_ctrl: got %h required 0", bus_m.out_ctrl); end
    checks++; if (bus_m.out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h required 0", bus_m.out_data); end
    checks++; if (bus_m.occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy: got %0d required 0", bus_m.occupancy); end
    checks++; if (bus_m.bubble_cnt !== '0) begin failures++; $display("FAIL reset_bubble_cnt: got %0d required 0", bus_m.bubble_cnt); end
    checks++; if (bus_m.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", bus_m.in_ready); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      bus_m.in_valid = 1'b1;
      bus_m.in_ctrl  = 9'h1FF;
      bus_m.in_data  = DW'(i);
      step();
      checks++;
      if (bus_m.out_valid !== 1'b1 || bus_m.out_data !== DW'(i) || bus_m.occupancy !== 2'd1) begin
        failures++;
        $display("FAIL stream_latency: entry %0d got valid=%b data=%0h occ=%0d, required valid=1 data=%0h occ=1",
                 i, bus_m.out_valid, bus_m.out_data, bus_m.occupancy, i);
      end
    end
    idle();
    step();
    checks++; if (bus_m.out_valid !== 1'b0 || bus_m.occupancy !== 2'd0) begin failures++; $display("FAIL stream_empty: got valid=%b occ=%0d, required 0 0", bus_m.out_valid, bus_m.occupancy); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL stream_pending: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_back_pressure();
    int  next = 0;
    int  maxocc = 0;
    bit  stalled = 1'b0;
    int  pops0 = pops;
    idle();
    for (int c = 0; c < 40 && (next < 6 || sb.size() != 0); c++) begin
      bus_m.out_ready = !(c >= 2 && c <= 4);
      bus_m.in_valid  = (next < 6);
      bus_m.in_ctrl   = CW'(next + 1);
      bus_m.in_data   = DW'(100 + next);
      #1;
      if (bus_m.in_valid && bus_m.in_ready) next++;
      if (bus_m.in_valid && !bus_m.in_ready) stalled = 1'b1;
      step();
      if (int'(bus_m.occupancy) > maxocc) maxocc = int'(bus_m.occupancy);
    end
    idle();
    checks++; if (maxocc != MAXOCC) begin failures++; $display("FAIL bp_max_occ: got %0d required %0d", maxocc, MAXOCC); end
    checks++; if (!stalled) begin failures++; $display("FAIL bp_in_ready: got no stall, required in_ready=0 while held"); end
    checks++; if (next != 6 || pops - pops0 != 6) begin failures++; $display("FAIL bp_count: got accepted=%0d emitted=%0d, required 6 6", next, pops - pops0); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_pending: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_bubble();
    idle();
    bus_m.in_valid  = 1'b1;
    bus_m.in_ctrl   = 9'h0A5;
    bus_m.in_data   = DW'(32'hDEAD_BEEF);
    bus_m.bubble    = 1'b1;
    bus_m.out_ready = 1'b0;
    step();
    bub_exp++;
    checks++; if (bus_m.out_valid !== 1'b1) begin failures++; $display("FAIL bubble_valid: got %b required 1", bus_m.out_valid); end
    checks++; if (bus_m.out_ctrl !== '0) begin failures++; $display("FAIL bubble_ctrl: got %h required 0", bus_m.out_ctrl); end
    checks++; if (bus_m.out_data[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bubble_data: got %h required deadbeef", bus_m.out_data[31:0]); end
    checks++; if (bus_m.bubble_cnt !== NW'(bub_exp)) begin failures++; $display("FAIL bubble_cnt: got %0d required %0d", bus_m.bubble_cnt, bub_exp); end
    bus_m.in_valid  = 1'b0;
    bus_m.out_ready = 1'b1;
    step();
    checks++; if (bus_m.bubble_cnt !== NW'(bub_exp) || bus_m.out_valid !== 1'b0) begin failures++; $display("FAIL bubble_no_valid: got cnt=%0d valid=%b, required cnt=%0d valid=0", bus_m.bubble_cnt, bus_m.out_valid, bub_exp); end
    idle();
  endtask

  task automatic test_saturation();
    int want;
    idle();
    for (int k = 0; k < 5; k++) begin
      bus_s.in_valid = 1'b1;
      bus_s.bubble   = 1'b1;
      bus_s.in_ctrl  = 9'h1FF;
      bus_s.in_data  = 32'(k);
      step();
      want = (k + 1 > 3) ? 3 : k + 1;
      checks++; if (bus_s.bubble_cnt !== 2'(want)) begin failures++; $display("FAIL sat_cnt: bubble %0d got %0d required %0d", k + 1, bus_s.bubble_cnt, want); end
    end
    checks++; if (bus_s.out_ctrl !== '0 || bus_s.out_data !== 32'd4) begin failures++; $display("FAIL sat_entry: got ctrl=%h data=%h, required 0 4", bus_s.out_ctrl, bus_s.out_data); end
    idle();
  endtask

  task automatic test_flush();
    idle();
    bus_m.out_ready = 1'b0;
    bus_m.in_valid  = 1'b1;
    bus_m.in_ctrl   = 9'h003;
    bus_m.in_data   = DW'(32'hA);
    step();
    bus_m.in_data   = DW'(32'hB);
    step();
    checks++; if (bus_m.occupancy !== 2'(MAXOCC)) begin failures++; $display("FAIL flush_fill: got occ=%0d required %0d", bus_m.occupancy, MAXOCC); end
    bus_m.flush   = 1'b1;
    bus_m.bubble  = 1'b1;
    bus_m.in_data = DW'(32'hC);
    #1;
    checks++; if (bus_m.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready: got %b required 0", bus_m.in_ready); end
    step();
    idle();
    bus_m.out_ready = 1'b0;
    #1;
    checks++; if (bus_m.out_valid !== 1'b0 || bus_m.occupancy !== 2'd0 || bus_m.out_ctrl !== '0) begin failures++; $display("FAIL flush_clear: got valid=%b occ=%0d ctrl=%h, required 0 0 0", bus_m.out_valid, bus_m.occupancy, bus_m.out_ctrl); end
    checks++; if (bus_m.bubble_cnt !== NW'(bub_exp)) begin failures++; $display("FAIL flush_cnt: got %0d required %0d", bus_m.bubble_cnt, bub_exp); end
    bus_m.out_ready = 1'b1;
    step();
    checks++; if (bus_m.out_valid !== 1'b0 || sb.size() != 0) begin failures++; $display("FAIL flush_dropped: got valid=%b pending=%0d, required 0 0", bus_m.out_valid, sb.size()); end
  endtask

  task automatic test_toggle();
    int next = 0;
    int pops0 = pops;
    idle();
    for (int c = 0; c < 60 && (next < 10 || sb.size() != 0); c++) begin
      bus_m.out_ready = c[0];
      bus_m.in_valid  = (next < 10);
      bus_m.in_ctrl   = CW'(9'h100 + next);
      bus_m.in_data   = DW'(32'h5000 + next);
      #1;
      if (bus_m.in_valid && bus_m.in_ready) next++;
      step();
    end
    drain();
    checks++; if (next != 10 || pops - pops0 != 10 || sb.size() != 0) begin failures++; $display("FAIL toggle_count: got accepted=%0d emitted=%0d pending=%0d, required 10 10 0", next, pops - pops0, sb.size()); end
  endtask

  task automatic test_async_reset();
    idle();
    bus_m.out_ready = 1'b0;
    bus_m.in_valid  = 1'b1;
    bus_m.in_ctrl   = 9'h0F0;
    bus_m.in_data   = DW'(32'h77);
    step();
    bus_m.in_data   = DW'(32'h78);
    step();
    bus_m.in_valid  = 1'b0;
    checks++; if (bus_m.occupancy !== 2'(MAXOCC)) begin failures++; $display("FAIL areset_fill: got occ=%0d required %0d", bus_m.occupancy, MAXOCC); end
    reset = 1'b1;
    #1;
    checks++; if (bus_m.out_valid !== 1'b0 || bus_m.occupancy !== 2'd0) begin failures++; $display("FAIL areset_immediate: got valid=%b occ=%0d, required 0 0", bus_m.out_valid, bus_m.occupancy); end
    checks++; if (bus_m.bubble_cnt !== '0) begin failures++; $display("FAIL areset_cnt: got %0d required 0", bus_m.bubble_cnt); end
    reset = 1'b0;
    sb.delete();
    bub_exp = 0;
    bus_m.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus_m.out_valid !== 1'b0) begin failures++; $display("FAIL areset_no_emit: cycle %0d got valid=%b required 0", k, bus_m.out_valid); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_stream();
    test_back_pressure();
    test_bubble();
    test_saturation();
    test_flush();
    test_toggle();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
